// File: rtl/palu_pkg.sv
// Shared definitions for the PALU datapath and its two-requester arbiter.
// Holds the op encoding, the data width and the packed response payload.
package palu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_NOT = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  // Registered response payload: result, carry-out and winning requester.
  typedef struct packed {
    logic [DATA_W-1:0] f;
    logic              ovf;
    logic              id;
  } palu_rsp_t;

endpackage

// File: rtl/eightbit_palu.sv
// eightbit_palu: combinational 8-bit ALU (add, not b, and, or).
// Ports:
//   sel  in  2       op select (OP_ADD / OP_NOT / OP_AND / OP_OR)
//   a    in  DATA_W  operand a
//   b    in  DATA_W  operand b
//   f    out DATA_W  result
//   ovf  out 1       carry-out of the add; 0 for every other op
module eightbit_palu
  import palu_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] f,
  output logic              ovf
);

  // Op decode; the add is computed one bit wider to expose the carry.
  always_comb begin
    f   = '0;
    ovf = 1'b0;
    case (sel)
      OP_ADD:  {ovf, f} = (DATA_W+1)'(a) + (DATA_W+1)'(b);
      OP_NOT:  f = ~b;
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/palu_arbiter.sv
// palu_arbiter: round-robin share of one eightbit_palu between two
// valid/ready requesters, with a single backpressured response register.
// Optional statistics counters are built when PALU_ARB_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready [2]  per-requester handshake (bit i = requester i)
//   req_sel [4]              {sel1, sel0}
//   req_a, req_b [16]        {x1, x0} operands
//   rsp_valid/rsp_ready      response handshake
//   rsp_f, rsp_ovf, rsp_id   registered result, carry-out, winning requester
//   stat_grant0/1, stat_ovf  saturating counters (STAT_W bits)
module palu_arbiter
  import palu_pkg::*;
#(
  parameter int unsigned RR_INIT = 0,
  parameter int unsigned STAT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [3:0]          req_sel,
  input  logic [15:0]         req_a,
  input  logic [15:0]         req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_f,
  output logic                rsp_ovf,
  output logic                rsp_id,
  output logic [STAT_W-1:0]   stat_grant0,
  output logic [STAT_W-1:0]   stat_grant1,
  output logic [STAT_W-1:0]   stat_ovf
);

  logic              prio;
  logic              rsp_valid_q;
  palu_rsp_t         rsp_q;
  logic              can_accept;
  logic [1:0]        grant;
  logic              gid;
  logic              accept;
  logic [1:0]        palu_sel;
  logic [DATA_W-1:0] palu_a;
  logic [DATA_W-1:0] palu_b;
  logic [DATA_W-1:0] palu_f;
  logic              palu_ovf;

  // Round-robin pick: a lone requester wins, a tie goes to prio.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign gid        = grant[1];
  assign can_accept = !rsp_valid_q || rsp_ready;
  assign req_ready  = (can_accept && !reset) ? grant : 2'b00;
  assign accept     = |(req_valid & req_ready);

  // Operand mux feeding the shared PALU.
  assign palu_sel = gid ? req_sel[3:2]  : req_sel[1:0];
  assign palu_a   = gid ? req_a[15:8]   : req_a[7:0];
  assign palu_b   = gid ? req_b[15:8]   : req_b[7:0];

  eightbit_palu u_palu (
    .sel (palu_sel),
    .a   (palu_a),
    .b   (palu_b),
    .f   (palu_f),
    .ovf (palu_ovf)
  );

  // Response register and priority pointer; accept wins over drain so a
  // simultaneous drain+accept leaves no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      prio        <= 1'(RR_INIT);
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= '{f: palu_f, ovf: palu_ovf, id: gid};
      prio        <= ~gid;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_q.f;
  assign rsp_ovf   = rsp_q.ovf;
  assign rsp_id    = rsp_q.id;

`ifdef PALU_ARB_STATS_EN
  logic [STAT_W-1:0] grant0_q;
  logic [STAT_W-1:0] grant1_q;
  logic [STAT_W-1:0] ovf_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_q <= '0;
      grant1_q <= '0;
      ovf_q    <= '0;
    end else if (accept) begin
      if (!gid && (grant0_q != '1)) grant0_q <= grant0_q + STAT_W'(1);
      if (gid && (grant1_q != '1))  grant1_q <= grant1_q + STAT_W'(1);
      if (palu_ovf && (ovf_q != '1)) ovf_q   <= ovf_q + STAT_W'(1);
    end
  end

  assign stat_grant0 = grant0_q;
  assign stat_grant1 = grant1_q;
  assign stat_ovf    = ovf_q;
`else
  assign stat_grant0 = '0;
  assign stat_grant1 = '0;
  assign stat_ovf    = '0;
`endif

endmodule

// File: tb/tb_palu_arbiter.sv
// Bench for palu_arbiter: directed requester drivers, a grant/ready model
// that pushes hand-computed responses into a scoreboard queue, and a
// separate monitor that pops and compares on every response handshake.
module tb_palu_arbiter;
  import palu_pkg::*;

  localparam int unsigned STAT_W = 4;
`ifdef PALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [7:0]        rsp_f;
  logic              rsp_ovf;
  logic              rsp_id;
  logic [STAT_W-1:0] stat_grant0, stat_grant1, stat_ovf;

  logic       v0 = 1'b0, v1 = 1'b0;
  logic [1:0] s0 = '0, s1 = '0;
  logic [7:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [7:0] e_f [2];
  logic       e_ovf [2];

  logic [1:0]  req_valid;
  logic [3:0]  req_sel;
  logic [15:0] req_a, req_b;
  assign req_valid = {v1, v0};
  assign req_sel   = {s1, s0};
  assign req_a     = {a1, a0};
  assign req_b     = {b1, b0};

  int checks = 0;
  int errors = 0;
  palu_rsp_t sb_q[$];
  logic m_prio  = 1'b0;
  logic m_valid = 1'b0;

  palu_arbiter #(.RR_INIT(0), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id),
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_ovf(stat_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Requester obligations: hold valid and payload while waiting.
  a_hold0: assert property (@(posedge clk) disable iff (reset)
    (req_valid[0] && !req_ready[0]) |=> (req_valid[0] && $stable(req_sel[1:0])
      && $stable(req_a[7:0]) && $stable(req_b[7:0])));
  a_hold1: assert property (@(posedge clk) disable iff (reset)
    (req_valid[1] && !req_ready[1]) |=> (req_valid[1] && $stable(req_sel[3:2])
      && $stable(req_a[15:8]) && $stable(req_b[15:8])));

  // Grant/ready model; pushes the expected response for each accept.
  always @(negedge clk) begin
    logic [1:0] eg, er;
    int i;
    if (reset) begin
      chk("ready_in_reset", 32'(req_ready), 32'd0);
      m_valid = 1'b0;
      m_prio  = 1'b0;
      sb_q.delete();
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (req_valid == 2'b11) eg = m_prio ? 2'b10 : 2'b01;
      else                    eg = req_valid;
      er = (!m_valid || rsp_ready) ? eg : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(er));
      if (er != 2'b00) begin
        i = er[1] ? 1 : 0;
        sb_q.push_back('{f: e_f[i], ovf: e_ovf[i], id: er[1]});
        m_prio  = ~er[1];
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: compare every response handshake against the scoreboard.
  always @(negedge clk) begin
    palu_rsp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_f",   32'(rsp_f),   32'(e.f));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
        chk("rsp_id",  32'(rsp_id),  32'(e.id));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] s,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ef, input logic eo);
    e_f[i] = ef;
    e_ovf[i] = eo;
    if (i == 1) begin v1 = v; s1 = s; a1 = a; b1 = b; end
    else        begin v0 = v; s0 = s; a0 = a; b0 = b; end
  endtask

  // Hold a request valid until it has been accepted n times.
  task automatic drive(input int i, input int n, input logic [1:0] s,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ef, input logic eo);
    int got = 0;
    int cyc = 0;
    sync();
    set_req(i, 1'b1, s, a, b, ef, eo);
    while (got < n && cyc < 200) begin
      @(negedge clk);
      if (req_ready[i]) got++;
      sync();
      cyc++;
    end
    chk("drive_accepts", 32'(got), 32'(n));
    if (i == 1) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input int g0, input int g1, input int ov);
    chk({tag, "_g0"},  32'(stat_grant0), STATS ? 32'(g0) : 32'd0);
    chk({tag, "_g1"},  32'(stat_grant1), STATS ? 32'(g1) : 32'd0);
    chk({tag, "_ovf"}, 32'(stat_ovf),    STATS ? 32'(ov) : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    e_f[0] = '0; e_f[1] = '0; e_ovf[0] = 1'b0; e_ovf[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_f", 32'(rsp_f), 32'd0);
    chk("reset_id", 32'(rsp_id), 32'd0);
    chk_stats("reset", 0, 0, 0);

    // Single add, no overflow.
    drive(0, 1, OP_ADD, 8'h54, 8'hAA, 8'hFE, 1'b0);
    @(negedge clk);
    chk("add_f", 32'(rsp_f), 32'hFE);
    chk("add_ovf", 32'(rsp_ovf), 32'd0);

    // Add with overflow from requester 1.
    drive(1, 1, OP_ADD, 8'hAB, 8'h55, 8'h00, 1'b1);
    @(negedge clk);
    chk("addc_f", 32'(rsp_f), 32'h00);
    chk("addc_ovf", 32'(rsp_ovf), 32'd1);
    chk("addc_id", 32'(rsp_id), 32'd1);
    chk_stats("addc", 1, 1, 1);

    // Contention: grants must alternate 0,1,0,1...
    fork
      drive(0, 5, OP_NOT, 8'h12, 8'hAA, 8'h55, 1'b0);
      drive(1, 5, OP_AND, 8'h55, 8'hFF, 8'h55, 1'b0);
    join
    @(negedge clk);
    chk_stats("rr", 6, 6, 1);

    // Backpressure: pending response held while rsp_ready is low.
    sync();
    rsp_ready = 1'b0;
    drive(1, 1, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0);
    fork
      drive(0, 1, OP_OR, 8'h0F, 8'hF0, 8'hFF, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_valid", 32'(rsp_valid), 32'd1);
          chk("bp_f", 32'(rsp_f), 32'h30);
          chk("bp_ready", 32'(req_ready), 32'd0);
        end
        sync();
        rsp_ready = 1'b1;
      end
    join
    @(negedge clk);
    chk("bp_next_f", 32'(rsp_f), 32'hFF);
    chk("bp_next_ovf", 32'(rsp_ovf), 32'd0);
    chk("bp_next_id", 32'(rsp_id), 32'd0);
    chk_stats("bp", 7, 7, 1);

    // Reset mid-operation with a pending response and both requesters valid.
    sync();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0);
    set_req(1, 1'b1, OP_OR, 8'h10, 8'h01, 8'h11, 1'b0);
    sync();
    sync();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_f", 32'(rsp_f), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_first_grant", 32'(req_ready), 32'b01);
    chk_stats("rst", 0, 0, 0);
    sync();
    v0 = 1'b0;
    rsp_ready = 1'b1;
    sync();
    v1 = 1'b0;

    // Saturation of the grant counter.
    drive(0, 20, OP_OR, 8'h0F, 8'hF0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("sat_g0", 32'(stat_grant0), STATS ? 32'hF : 32'd0);

    repeat (3) sync();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/palu_arbiter.md
Name: palu_arbiter

Overview:
Shares one `eightbit_palu` between two requesters, each with its own valid/ready request channel. A round-robin grant picks one request per cycle and drives the PALU with that request's operands. The PALU result and overflow go into a single response register, tagged with the winning requester's ID, and that register has valid/ready backpressure. The block sits between the two operation sources (sequencers or microcode engines) and the shared PALU datapath.

Parameters:
- RR_INIT, 0: requester that holds priority after reset (0 or 1).
- STAT_W, 16: width of the statistics counters. Used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i belongs to requester i
- req_ready  out  2  per-requester accept
- req_sel  in  4  {sel1, sel0}; each is a 2-bit PALU op: 0 add, 1 not b, 2 and, 3 or
- req_a  in  16  {a1, a0}; 8-bit operand a per requester
- req_b  in  16  {b1, b0}; 8-bit operand b per requester
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_f  out  8  registered PALU result
- rsp_ovf  out  1  registered carry-out; 1 only for add
- rsp_id  out  1  index of the requester that produced the response
- stat_grant0  out  STAT_W  grants issued to requester 0
- stat_grant1  out  STAT_W  grants issued to requester 1
- stat_ovf  out  STAT_W  add operations that overflowed

Behaviour:
- State:
  - rsp register: valid, f, ovf, id.
  - 1-bit priority pointer prio = requester currently favoured.
- can_accept = !rsp_valid || rsp_ready. Purely combinational.
- Grant:
  - Only one requester valid: it wins.
  - Both valid: requester prio wins.
  - None valid: no grant.
- Ready:
  - req_ready[i] = can_accept && grant[i].
  - Ready may depend combinationally on req_valid and rsp_ready.
  - At most one req_ready bit is high in any cycle.
- Accept (edge where req_valid[i] && req_ready[i]):
  - rsp_f/rsp_ovf <= PALU outputs for requester i's sel/a/b.
  - rsp_id <= i; rsp_valid <= 1; prio <= ~i.
- Latency and throughput:
  - Response is visible the cycle after accept.
  - Full throughput is one op per cycle while rsp_ready = 1.
- Drain: rsp_valid && rsp_ready with no accept that cycle → rsp_valid <= 0. The data fields hold their last values.
- Backpressure: rsp_valid && !rsp_ready → rsp_valid, rsp_f, rsp_ovf and rsp_id are held stable, and req_ready = 0.
- Arithmetic:
  - add gives {ovf,f} = a + b as a 9-bit sum.
  - not, and, or give ovf = 0.
- Requester obligations: hold sel/a/b stable while valid && !ready, and do not deassert valid before acceptance. The bench checks this with assertions.
- Priority moves only on a grant. An idle cycle keeps prio unchanged.
- Reset, applied with priority over everything including mid-transfer:
  - rsp_valid, rsp_f, rsp_ovf and rsp_id go to 0.
  - prio goes to RR_INIT.
  - Statistics clear.
  - A pending response is discarded.
  - req_ready = 0 while reset is high.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one, with no bubble.

Optional Feature:
PALU_ARB_STATS_EN
- Defined:
  - stat_grant0 and stat_grant1 increment on each accept by that requester.
  - stat_ovf increments on each accept whose computed ovf = 1.
  - All counters saturate at all-ones and clear on reset.
- Undefined: the counter logic is omitted and the stat ports are tied to 0. The port list is identical either way.

Decomposition:
- Shared package `palu_pkg` holds:
  - op encoding constants OP_ADD = 2'd0, OP_NOT = 2'd1, OP_AND = 2'd2, OP_OR = 2'd3;
  - DATA_W = 8;
  - a response struct typedef {f, ovf, id}.
- Sub-module: the existing `eightbit_palu`, instantiated once and driven by the grant mux.
- The round-robin picker stays inline; it is too small to be a separate module.

Test Plan:
- Single add, no overflow: req0 sel=0, a=0x54, b=0xAA, rsp_ready=1 → next cycle rsp_valid=1, f=0xFE, ovf=0, id=0.
- Add with overflow: req1 sel=0, a=0xAB, b=0x55 → f=0x00, ovf=1, id=1. With STATS_EN, stat_ovf=1.
- Contention and fairness: both requesters valid continuously, rsp_ready=1, RR_INIT=0 → grants alternate 0,1,0,1. Responses: f=~0xAA=0x55 for req0 (sel=1), f=0x55&0xFF=0x55 for req1 (sel=2, a=0x55, b=0xFF). Over 10 ops, stat_grant0 = stat_grant1 = 5.
- Backpressure: response pending, rsp_ready=0 for 3 cycles with req0 valid (sel=3, a=0x0F, b=0xF0) → req_ready=0 and the response is held stable. On rsp_ready=1 the old response is consumed and req0 is accepted the same cycle. The next response is f=0xFF, ovf=0.
- Reset mid-operation: response valid and both requesters valid, assert reset for 1 cycle → rsp_valid=0, f=0, id=0, stats=0, req_ready=0 during reset. The first grant after reset goes to RR_INIT when both are valid.
- Saturation (STATS_EN, STAT_W=4): 20 grants to req0 → stat_grant0 stays at 0xF.
